// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window sequencing path.
// Latency: none (types, constants and one combinational helper only).
package sobel_pkg;
    localparam int PIX_W          = 8;
    localparam int DEF_IMG_WIDTH  = 540;
    localparam int DEF_IMG_HEIGHT = 360;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH,
        DRAIN
    } state_t;

    function automatic logic at_edge(input int pos, input int last);
        return (pos == 0) || (pos == last);
    endfunction
endpackage

// File: rtl/raster_counter.sv
// Row/column raster position counter: advances on enable, wraps at frame end, flags border positions.
// Latency: one cycle from enable to new position; no backpressure, the caller gates enable.
module raster_counter
    import sobel_pkg::*;
#(
    parameter int W     = DEF_IMG_WIDTH,
    parameter int H     = DEF_IMG_HEIGHT,
    parameter int COL_W = $clog2(W),
    parameter int ROW_W = $clog2(H)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             border
);
    always_ff @(posedge clock) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (enable) begin
            if (col == COL_W'(W - 1)) begin
                col <= '0;
                row <= (row == ROW_W'(H - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign border = at_edge(int'(row), H - 1) || at_edge(int'(col), W - 1);
endmodule

// File: rtl/window_ctrl.sv
// Sequences the 3x3 line-buffer shift register and hands one window per centre pixel downstream.
// Latency: window valid one cycle after its shift; no shift while a held window is unconsumed, so in_ready drops under win_ready backpressure.
module window_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int COL_W      = $clog2(IMG_WIDTH),
    parameter int ROW_W      = $clog2(IMG_HEIGHT),
    parameter int CNT_W      = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             sr_shift_en,
    output logic [PIX_W-1:0] sr_pixel_in,
    output logic             win_valid,
    input  logic             win_ready,
    output logic             win_border,
    output logic [ROW_W-1:0] out_row,
    output logic [COL_W-1:0] out_col,
    output logic             frame_done
);
    localparam int FL_W = $clog2(IMG_WIDTH + 1);
    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(IMG_WIDTH);
    localparam logic [CNT_W-1:0] PIX_LAST   = CNT_W'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(IMG_WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] pix_cnt;
    logic [FL_W-1:0]  flush_cnt;
    logic             free;
    logic             consume;
    logic             shift;
    logic             win_shift;
    logic [ROW_W-1:0] ctr_row;
    logic [COL_W-1:0] ctr_col;
    logic             ctr_border;

    assign free        = !win_valid || win_ready;
    assign consume     = win_valid && win_ready;
    assign win_shift   = shift && (state == RUN || state == FLUSH);
    assign sr_shift_en = shift;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (shift && pix_cnt == FILL_LAST) state_nxt = RUN;
            RUN:     if (shift && pix_cnt == PIX_LAST) state_nxt = FLUSH;
            FLUSH:   if (shift && flush_cnt == FLUSH_LAST) state_nxt = DRAIN;
            DRAIN:   if (consume) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // FILL ignores downstream state: no window exists until the first RUN shift.
    always_comb begin
        in_ready    = 1'b0;
        shift       = 1'b0;
        sr_pixel_in = in_pixel;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                shift    = in_valid;
            end
            RUN: begin
                in_ready = free;
                shift    = in_valid && free;
            end
            FLUSH: begin
                shift       = free;
                sr_pixel_in = '0;
            end
            default: ;
        endcase
    end

    raster_counter #(
        .W     (IMG_WIDTH),
        .H     (IMG_HEIGHT),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_centre (
        .clock  (clock),
        .reset  (reset),
        .enable (win_shift),
        .row    (ctr_row),
        .col    (ctr_col),
        .border (ctr_border)
    );

    // The counter holds the next centre; it is latched into the outputs with each window shift.
    always_ff @(posedge clock) begin
        if (reset) begin
            pix_cnt    <= '0;
            flush_cnt  <= '0;
            win_valid  <= 1'b0;
            win_border <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == DRAIN) && consume;
            if (shift && (state == FILL || state == RUN)) begin
                pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
            end
            if (shift && state == FLUSH) begin
                flush_cnt <= (flush_cnt == FLUSH_LAST) ? '0 : flush_cnt + 1'b1;
            end
            if (win_shift) begin
                win_valid  <= 1'b1;
                out_row    <= ctr_row;
                out_col    <= ctr_col;
                win_border <= ctr_border;
            end else if (consume) begin
                win_valid <= 1'b0;
            end
        end
    end
endmodule
